ysyx_220066_dmem: RTL and testbench
===================================

YSYX_220066_DMEM -- requirements
Module: ysyx_220066_dmem

Interface
REQ-001 SHALL have parameter ADDR_BASE, default 64'h0000_0000_8000_0000, byte address of memory word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 12, giving 2^DEPTH_LOG2 64-bit words.
REQ-003 SHALL have parameter LAT, default 2, range 0..15, giving extra wait cycles before response.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, CPU request present.
REQ-007 SHALL have port req_ready, output, 1, block accepts request this cycle.
REQ-008 SHALL have ports MemRd and MemWr, input, 1 each, read and write request qualifiers.
REQ-009 SHALL have port MemOp, input, 3, access size/sign (RISC-V funct3 encoding).
REQ-010 SHALL have ports addr and data_Wr, input, 64 each, byte address and store data.
REQ-011 SHALL have port rsp_valid, output, 1, response present.
REQ-012 SHALL have port rsp_ready, input, 1, CPU consumes response.
REQ-013 SHALL have ports data_Rd, output, 64, load result, and rsp_err, output, 1, access fault.

Function
REQ-014 SHALL implement FSM IDLE, BUSY, RESP; req_ready=1 only in IDLE with rst=0.
REQ-015 SHALL accept on req_valid&&req_ready, capturing MemRd, MemWr, MemOp, addr and data_Wr.
REQ-016 SHALL transition IDLE->BUSY on accept when LAT>0 (counter loaded with LAT-1), and IDLE->RESP when LAT=0.
REQ-017 SHALL decrement the counter in BUSY and enter RESP on the edge where it is 0; rsp_valid first rises LAT+1 cycles after the accept edge.
REQ-018 SHALL hold rsp_valid, data_Rd and rsp_err stable in RESP until rsp_ready=1, then return to IDLE on that edge; a new request is accepted no earlier than the following cycle.
REQ-019 SHALL decode MemOp as 000 byte signed, 001 half signed, 010 word signed, 011 double, 100 byte unsigned, 101 half unsigned, 110 word unsigned, 111 illegal.
REQ-020 SHALL on a read select the word (addr-ADDR_BASE)>>3, shift it right by addr[2:0]*8, then sign- or zero-extend it to 64 bits per MemOp.
REQ-021 SHALL on a write update only byte lanes addr[2:0] through addr[2:0]+size-1, taking the low size bytes of data_Wr; store MemOp 1xx is illegal.
REQ-022 SHALL commit the write and sample the read data on the edge entering RESP, so read-after-write sees the new data.
REQ-023 SHALL set rsp_err=1, perform no write and return data_Rd=0 when: MemRd&&MemWr; neither is set; MemOp illegal; or the address is outside [ADDR_BASE, ADDR_BASE+8*2^DEPTH_LOG2).
REQ-024 SHALL require each access (addr to addr+size-1) to lie within one 64-bit word when misalignment handling is compiled out (REQ-029).

Reset
REQ-025 SHALL while rst=1 force state IDLE, req_ready=0, rsp_valid=0, data_Rd=0, rsp_err=0 and the counter to 0.
REQ-026 SHALL on rst during BUSY discard the request with no write committed; during RESP the committed write is kept and the response is dropped.
REQ-027 SHALL leave memory contents unchanged by reset.

Configuration
REQ-028 SHALL gate misalignment checking by macro YSYX_220066_DMEM_MISALIGN_EN.
REQ-029 SHALL with the macro defined flag any access with addr not a multiple of size as rsp_err=1, with no write and data_Rd=0.
REQ-030 SHALL with the macro undefined force addr low bits to natural alignment (clear log2(size) LSBs) and never raise rsp_err for misalignment.

Verification
REQ-031 SHALL cover: LAT=2, store sd 64'h1122334455667788 to 0x80000000 then load ld -> rsp_valid 3 cycles after each accept, data_Rd=64'h1122334455667788, rsp_err=0.
REQ-032 SHALL cover: after REQ-031, lb at 0x80000007 -> data_Rd=64'h11; lh at 0x80000000 -> 64'h7788; sb 8'hF0 at 0x80000002 then lbu -> 64'hF0, lb -> 64'hFFFF_FFFF_FFFF_FFF0.
REQ-033 SHALL cover: load at 0x7FFFFFF8 and MemOp=111 at 0x80000000 -> rsp_err=1, data_Rd=0, no memory change.
REQ-034 SHALL cover: response held with rsp_ready=0 for 5 cycles -> rsp_valid/data_Rd stable and req_ready=0 throughout; accepted next cycle after rsp_ready=1.
REQ-035 SHALL cover: rst asserted 1 cycle after accepting sd 64'hDEAD to 0x80000008 -> no response, word stays prior value, req_ready=1 the cycle after rst drops.
REQ-036 SHALL cover: lw at 0x80000002 -> rsp_err=1 with YSYX_220066_DMEM_MISALIGN_EN, word at 0x80000000 returned with rsp_err=0 without it.

Source files
------------

// File: rtl/ysyx_220066_dmem.sv
// rtl/ysyx_220066_dmem.sv - latency-configurable 64-bit data memory with valid/ready request and response
//
// Purpose: the CPU data memory. It accepts one load or store at a time, waits
// LAT cycles, then presents a response that is held until it is consumed.
// Optional build macro: YSYX_220066_DMEM_MISALIGN_EN. When it is defined,
// misaligned accesses fault. When it is not defined, addresses are forced
// down to natural alignment.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present           req_ready  request accepted this cycle
//   MemRd      load qualifier            MemWr      store qualifier
//   MemOp      funct3 size/sign code     addr       byte address
//   data_Wr    store data (low bytes)
//   rsp_valid  response present          rsp_ready  response consumed
//   data_Rd    load result (0 on fault)  rsp_err    access fault

module ysyx_220066_dmem #(
   parameter logic [63:0] ADDR_BASE  = 64'h0000_0000_8000_0000,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LAT        = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic [2:0]  MemOp,
   input  logic [63:0] addr,
   input  logic [63:0] data_Wr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] data_Rd,
   output logic        rsp_err
);

   localparam int         WORDS    = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_LOAD = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        capture, enter_resp;

   logic        rd_q, wr_q;
   logic [2:0]  op_q;
   logic [63:0] addr_q, wdata_q;

   logic [63:0] rdata_q;
   logic        err_q;

   logic [63:0] mem [0:WORDS-1];

   // Access source: the live inputs when the response is formed on the
   // accept edge itself (LAT=0), otherwise the captured request.
   logic        src_rd, src_wr;
   logic [2:0]  src_op;
   logic [63:0] src_addr, src_wdata;

   logic [2:0]            size_mask;
   logic [7:0]            size_lanes, lane_mask;
   logic [63:0]           eff_addr, offset, bit_mask;
   logic [63:0]           word_old, word_shift, load_val, store_word;
   logic [2:0]            lane;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  bad_cmd, bad_op, out_range, misalign, acc_err;

   assign req_ready = (state == IDLE) && !rst;
   assign rsp_valid = (state == RESP) && !rst;
   assign data_Rd   = rst ? 64'd0 : rdata_q;
   assign rsp_err   = err_q && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (capture) begin
            rd_q    <= MemRd;
            wr_q    <= MemWr;
            op_q    <= MemOp;
            addr_q  <= addr;
            wdata_q <= data_Wr;
         end
         if (enter_resp) begin
            err_q   <= acc_err;
            rdata_q <= (acc_err || !src_rd) ? 64'd0 : load_val;
         end
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      capture    = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid && req_ready) begin
               capture = 1'b1;
               if (LAT == 0) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = BUSY;
                  cnt_n   = LAT_LOAD;
               end
            end
         end
         BUSY: begin
            if (cnt == 4'd0) begin
               state_n    = RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      if (state == IDLE) begin
         src_rd    = MemRd;
         src_wr    = MemWr;
         src_op    = MemOp;
         src_addr  = addr;
         src_wdata = data_Wr;
      end else begin
         src_rd    = rd_q;
         src_wr    = wr_q;
         src_op    = op_q;
         src_addr  = addr_q;
         src_wdata = wdata_q;
      end
   end

   always_comb begin
      size_mask  = 3'd7;
      size_lanes = 8'hFF;
      case (src_op[1:0])
         2'b00: begin size_mask = 3'd0; size_lanes = 8'h01; end
         2'b01: begin size_mask = 3'd1; size_lanes = 8'h03; end
         2'b10: begin size_mask = 3'd3; size_lanes = 8'h0F; end
         default: begin size_mask = 3'd7; size_lanes = 8'hFF; end
      endcase

      bad_cmd = (src_rd == src_wr);
      // 111 is never legal; unsigned codes make no sense for a store.
      bad_op  = (src_op == 3'b111) || (src_wr && src_op[2]);

`ifdef YSYX_220066_DMEM_MISALIGN_EN
      misalign = (src_addr[2:0] & size_mask) != 3'd0;
      eff_addr = src_addr;
`else
      misalign = 1'b0;
      eff_addr = src_addr & ~{61'd0, size_mask};
`endif

      offset    = eff_addr - ADDR_BASE;
      // Checking the offset's high bits avoids overflow of ADDR_BASE + size.
      out_range = (eff_addr < ADDR_BASE) || ((offset >> (DEPTH_LOG2 + 3)) != 64'd0);
      acc_err   = bad_cmd || bad_op || out_range || misalign;

      lane       = eff_addr[2:0];
      idx        = offset[DEPTH_LOG2+2:3];
      word_old   = mem[idx];
      word_shift = word_old >> {lane, 3'b000};

      case (src_op)
         3'b000:  load_val = {{56{word_shift[7]}},  word_shift[7:0]};
         3'b001:  load_val = {{48{word_shift[15]}}, word_shift[15:0]};
         3'b010:  load_val = {{32{word_shift[31]}}, word_shift[31:0]};
         3'b100:  load_val = {56'd0, word_shift[7:0]};
         3'b101:  load_val = {48'd0, word_shift[15:0]};
         3'b110:  load_val = {32'd0, word_shift[31:0]};
         default: load_val = word_shift;
      endcase

      lane_mask = size_lanes << lane;
      bit_mask  = 64'd0;
      for (int i = 0; i < 8; i++) begin
         bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
      end
      store_word = (word_old & ~bit_mask) | ((src_wdata << {lane, 3'b000}) & bit_mask);
   end

   // The write lands on the edge entering RESP, so a reset taken while BUSY
   // leaves memory untouched. Memory itself is never reset.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && src_wr && !acc_err) begin
         mem[idx] <= store_word;
      end
   end

endmodule

// File: tb/tb_ysyx_220066_dmem.sv
// tb/tb_ysyx_220066_dmem.sv - directed self-checking bench for ysyx_220066_dmem
module tb_ysyx_220066_dmem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        MemRd = 1'b0;
   logic        MemWr = 1'b0;
   logic [2:0]  MemOp = 3'd0;
   logic [63:0] addr = 64'd0;
   logic [63:0] data_Wr = 64'd0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] data_Rd;
   logic        rsp_err;

   int pass_cnt = 0;
   int total = 0;

   ysyx_220066_dmem dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .MemRd(MemRd), .MemWr(MemWr), .MemOp(MemOp), .addr(addr), .data_Wr(data_Wr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .data_Rd(data_Rd), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   // Drives one request, and returns the number of edges from the accept
   // edge up to the first response, plus the response.
   task automatic access(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] wd,
                         output int lat, output logic [63:0] d, output logic e);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; MemRd = rd; MemWr = wr; MemOp = op; addr = a; data_Wr = wd;
      rsp_ready = 1'b0;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      d = data_Rd;
      e = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (req_ready !== 1'b0) $display("FAIL rst_req_ready got %b want 0", req_ready); else pass_cnt++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid got %b want 0", rsp_valid); else pass_cnt++;
      total++; if (data_Rd !== 64'd0) $display("FAIL rst_data_Rd got %h want 0", data_Rd); else pass_cnt++;
      total++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err got %b want 0", rsp_err); else pass_cnt++;
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got %b want 1", req_ready); else pass_cnt++;
   endtask

   task automatic test_store_load;
      int lat; logic [63:0] d; logic e;
      access(1'b0, 1'b1, 3'b011, 64'h8000_0000, 64'h1122334455667788, lat, d, e);
      total++; if (lat !== 3) $display("FAIL sd_latency got %0d want 3", lat); else pass_cnt++;
      total++; if (e !== 1'b0) $display("FAIL sd_err got %b want 0", e); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (lat !== 3) $display("FAIL ld_latency got %0d want 3", lat); else pass_cnt++;
      total++; if (d !== 64'h1122334455667788) $display("FAIL ld_data got %h want 1122334455667788", d); else pass_cnt++;
      total++; if (e !== 1'b0) $display("FAIL ld_err got %b want 0", e); else pass_cnt++;
   endtask

   task automatic test_subword;
      int lat; logic [63:0] d; logic e;
      access(1'b1, 1'b0, 3'b000, 64'h8000_0007, 64'd0, lat, d, e);
      total++; if (d !== 64'h11) $display("FAIL lb7 got %h want 11", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b001, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (d !== 64'h7788) $display("FAIL lh0 got %h want 7788", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b010, 64'h8000_0004, 64'd0, lat, d, e);
      total++; if (d !== 64'h11223344) $display("FAIL lw4 got %h want 11223344", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b101, 64'h8000_0006, 64'd0, lat, d, e);
      total++; if (d !== 64'h1122) $display("FAIL lhu6 got %h want 1122", d); else pass_cnt++;
      access(1'b0, 1'b1, 3'b000, 64'h8000_0002, 64'hAAAA_AAAA_AAAA_AAF0, lat, d, e);
      total++; if (e !== 1'b0) $display("FAIL sb_err got %b want 0", e); else pass_cnt++;
      access(1'b1, 1'b0, 3'b100, 64'h8000_0002, 64'd0, lat, d, e);
      total++; if (d !== 64'hF0) $display("FAIL lbu2 got %h want f0", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b000, 64'h8000_0002, 64'd0, lat, d, e);
      total++; if (d !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL lb2 got %h want fffffffffffffff0", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (d !== 64'h1122334455F07788) $display("FAIL sb_merge got %h want 1122334455f07788", d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b110, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (d !== 64'h55F07788) $display("FAIL lwu0 got %h want 55f07788", d); else pass_cnt++;
   endtask

   task automatic test_errors;
      int lat; logic [63:0] d; logic e;
      access(1'b1, 1'b0, 3'b011, 64'h7FFF_FFF8, 64'd0, lat, d, e);
      total++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL below_base err %b data %h want 1 0", e, d); else pass_cnt++;
      access(1'b1, 1'b0, 3'b111, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL op111_ld err %b data %h want 1 0", e, d); else pass_cnt++;
      access(1'b0, 1'b1, 3'b111, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat, d, e);
      total++; if (e !== 1'b1) $display("FAIL op111_sd err %b want 1", e); else pass_cnt++;
      access(1'b0, 1'b1, 3'b100, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (e !== 1'b1) $display("FAIL store_unsigned err %b want 1", e); else pass_cnt++;
      access(1'b1, 1'b1, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL rd_and_wr err %b data %h want 1 0", e, d); else pass_cnt++;
      access(1'b0, 1'b0, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (e !== 1'b1) $display("FAIL no_cmd err %b want 1", e); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_8000, 64'd0, lat, d, e);
      total++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL above_top err %b data %h want 1 0", e, d); else pass_cnt++;
      access(1'b0, 1'b1, 3'b011, 64'h8000_7FF8, 64'hCAFE_F00D_1234_5678, lat, d, e);
      total++; if (e !== 1'b0) $display("FAIL last_word_sd err %b want 0", e); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_7FF8, 64'd0, lat, d, e);
      total++; if (d !== 64'hCAFE_F00D_1234_5678 || e !== 1'b0) $display("FAIL last_word_ld got %h err %b", d, e); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
      total++; if (d !== 64'h1122334455F07788) $display("FAIL err_no_write got %h want 1122334455f07788", d); else pass_cnt++;
   endtask

   task automatic test_hold;
      int guard; int lat;
      @(negedge clk);
      req_valid = 1'b1; MemRd = 1'b1; MemWr = 1'b0; MemOp = 3'b011; addr = 64'h8000_0000;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk);
      // A second request waits while the first response is held.
      addr = 64'h8000_7FF8;
      guard = 0;
      while (!rsp_valid && guard < 40) begin @(negedge clk); guard++; end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (rsp_valid !== 1'b1 || data_Rd !== 64'h1122334455F07788 || req_ready !== 1'b0)
            $display("FAIL hold_cycle%0d valid %b data %h ready %b want 1 1122334455f07788 0", i, rsp_valid, data_Rd, req_ready);
         else pass_cnt++;
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++; if (req_ready !== 1'b1) $display("FAIL hold_release_ready got %b want 1", req_ready); else pass_cnt++;
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
      total++;
      if (lat !== 3 || data_Rd !== 64'hCAFE_F00D_1234_5678)
         $display("FAIL hold_next lat %0d data %h want 3 cafef00d12345678", lat, data_Rd);
      else pass_cnt++;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_busy;
      int lat; logic [63:0] d; logic e; logic saw;
      access(1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h5555, lat, d, e);
      @(negedge clk);
      req_valid = 1'b1; MemRd = 1'b0; MemWr = 1'b1; MemOp = 3'b011; addr = 64'h8000_0008; data_Wr = 64'hDEAD;
      total++; if (req_ready !== 1'b1) $display("FAIL rb_ready got %b want 1", req_ready); else pass_cnt++;
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) $display("FAIL rb_in_rst valid %b ready %b want 0 0", rsp_valid, req_ready); else pass_cnt++;
      rst = 1'b0;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rb_after_rst_ready got %b want 1", req_ready); else pass_cnt++;
      saw = 1'b0;
      repeat (4) begin @(negedge clk); if (rsp_valid !== 1'b0) saw = 1'b1; end
      total++; if (saw !== 1'b0) $display("FAIL rb_no_response got %b want 0", saw); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_0008, 64'd0, lat, d, e);
      total++; if (d !== 64'h5555) $display("FAIL rb_word got %h want 5555", d); else pass_cnt++;
   endtask

   task automatic test_reset_resp;
      int guard; int lat; logic [63:0] d; logic e;
      @(negedge clk);
      req_valid = 1'b1; MemRd = 1'b0; MemWr = 1'b1; MemOp = 3'b011; addr = 64'h8000_0010; data_Wr = 64'h77;
      guard = 0;
      while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
      @(negedge clk);
      req_valid = 1'b0;
      guard = 0;
      while (!rsp_valid && guard < 40) begin @(negedge clk); guard++; end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rr_dropped valid %b ready %b want 0 1", rsp_valid, req_ready); else pass_cnt++;
      access(1'b1, 1'b0, 3'b011, 64'h8000_0010, 64'd0, lat, d, e);
      total++; if (d !== 64'h77) $display("FAIL rr_kept got %h want 77", d); else pass_cnt++;
   endtask

   task automatic test_misalign;
      int lat; logic [63:0] d; logic e;
      access(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'd0, lat, d, e);
`ifdef YSYX_220066_DMEM_MISALIGN_EN
      total++; if (e !== 1'b1 || d !== 64'd0) $display("FAIL lw_misalign err %b data %h want 1 0", e, d); else pass_cnt++;
`else
      total++; if (e !== 1'b0 || d !== 64'h55F07788) $display("FAIL lw_misalign err %b data %h want 0 55f07788", e, d); else pass_cnt++;
`endif
      access(1'b0, 1'b1, 3'b001, 64'h8000_0003, 64'hBEEF, lat, d, e);
      access(1'b1, 1'b0, 3'b011, 64'h8000_0000, 64'd0, lat, d, e);
`ifdef YSYX_220066_DMEM_MISALIGN_EN
      total++; if (d !== 64'h1122334455F07788) $display("FAIL sh_misalign got %h want 1122334455f07788", d); else pass_cnt++;
`else
      total++; if (d !== 64'h11223344BEEF7788) $display("FAIL sh_misalign got %h want 11223344beef7788", d); else pass_cnt++;
`endif
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_subword();
      test_errors();
      test_hold();
      test_reset_busy();
      test_reset_resp();
      test_misalign();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
